// File: rtl/alu_wide_sequencer.sv
// Drives one 32-bit ALU over one or two passes to perform 32/64-bit adds.
// Returns a 64-bit result with merged flags over a valid/ready response.
module alu_wide_sequencer #(
  parameter int          WORD_W     = 32,
  parameter logic [4:0]  FUNSEL_ADD = 5'b10100,
  parameter logic [4:0]  FUNSEL_ADC = 5'b10101
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [1:0]          ReqOp,
  input  logic [2*WORD_W-1:0] ReqA,
  input  logic [2*WORD_W-1:0] ReqB,
  output logic [WORD_W-1:0]   AluA,
  output logic [WORD_W-1:0]   AluB,
  output logic [4:0]          AluFunSel,
  output logic                AluWF,
  input  logic [WORD_W-1:0]   AluOut,
  input  logic [3:0]          AluFlags,
  output logic                RespValid,
  input  logic                RespReady,
  output logic [2*WORD_W-1:0] RespResult,
  output logic [3:0]          RespFlags,
  output logic                RespErr
);

  localparam logic [1:0] OP_ADD32 = 2'b00;
  localparam logic [1:0] OP_ADC64 = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [2*WORD_W-1:0] a_q, a_d;
  logic [2*WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0]   res_lo_q, res_lo_d;
  logic [WORD_W-1:0]   res_hi_q, res_hi_d;
  logic                z_lo_q, z_lo_d;
  logic [WORD_W-1:0]   alu_a_q, alu_a_d;
  logic [WORD_W-1:0]   alu_b_q, alu_b_d;
  logic [4:0]          alu_fs_q, alu_fs_d;
  logic                alu_wf_q, alu_wf_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [2*WORD_W-1:0] resp_result_q, resp_result_d;
  logic [3:0]          resp_flags_q, resp_flags_d;
  logic                resp_err_q, resp_err_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_lo_d      = res_lo_q;
    res_hi_d      = res_hi_q;
    z_lo_d        = z_lo_q;
    alu_a_d       = '0;
    alu_b_d       = '0;
    alu_fs_d      = '0;
    alu_wf_d      = 1'b0;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_err_d    = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (ReqValid && req_ready_q) begin
          op_d = ReqOp;
          a_d  = ReqA;
          b_d  = ReqB;
          if (ReqOp == OP_RSVD) begin
            state_d = RESP;
          end else begin
            state_d  = LO;
            alu_a_d  = ReqA[WORD_W-1:0];
            alu_b_d  = ReqB[WORD_W-1:0];
            alu_wf_d = 1'b1;
            alu_fs_d = (ReqOp == OP_ADC64) ? FUNSEL_ADC : FUNSEL_ADD;
          end
        end
      end
      LO: begin
        res_lo_d = AluOut;
        if (op_q == OP_ADD32) begin
          state_d = RESP;
        end else begin
          state_d  = HI;
          alu_a_d  = a_q[2*WORD_W-1:WORD_W];
          alu_b_d  = b_q[2*WORD_W-1:WORD_W];
          alu_fs_d = FUNSEL_ADC;
          alu_wf_d = 1'b1;
        end
      end
      HI: begin
        z_lo_d   = AluFlags[3];
        res_hi_d = AluOut;
        state_d  = RESP;
      end
      RESP: begin
        // First RESP cycle: WF is low, so AluFlags now holds the last pass.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = (op_q == OP_RSVD);
          if (op_q == OP_RSVD) begin
            resp_result_d = '0;
            resp_flags_d  = '0;
          end else if (op_q == OP_ADD32) begin
            resp_result_d = {{WORD_W{1'b0}}, res_lo_q};
            resp_flags_d  = AluFlags;
          end else begin
            resp_result_d = {res_hi_q, res_lo_q};
            resp_flags_d  = {z_lo_q & AluFlags[3], AluFlags[2:0]};
          end
        end else if (RespReady) begin
          resp_valid_d  = 1'b0;
          resp_result_d = '0;
          resp_flags_d  = '0;
          resp_err_d    = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_lo_q      <= '0;
      res_hi_q      <= '0;
      z_lo_q        <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_fs_q      <= '0;
      alu_wf_q      <= 1'b0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_lo_q      <= res_lo_d;
      res_hi_q      <= res_hi_d;
      z_lo_q        <= z_lo_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_fs_q      <= alu_fs_d;
      alu_wf_q      <= alu_wf_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign ReqReady   = req_ready_q;
  assign AluA       = alu_a_q;
  assign AluB       = alu_b_q;
  assign AluFunSel  = alu_fs_q;
  assign AluWF      = alu_wf_q;
  assign RespValid  = resp_valid_q;
  assign RespResult = resp_result_q;
  assign RespFlags  = resp_flags_q;
  assign RespErr    = resp_err_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer with a behavioural 32-bit ALU model.
// Table-driven vectors checked through an expected-response queue.
module tb_alu_wide_sequencer;

  localparam int         W   = 32;
  localparam logic [4:0] ADD = 5'b10100;
  localparam logic [4:0] ADC = 5'b10101;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic [1:0]    ReqOp = '0;
  logic [2*W-1:0] ReqA = '0;
  logic [2*W-1:0] ReqB = '0;
  logic [W-1:0]  AluA, AluB, AluOut;
  logic [4:0]    AluFunSel;
  logic          AluWF;
  logic [3:0]    AluFlags;
  logic          RespValid;
  logic          RespReady = 1'b1;
  logic [2*W-1:0] RespResult;
  logic [3:0]    RespFlags;
  logic          RespErr;

  alu_wide_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqA(ReqA), .ReqB(ReqB),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespResult(RespResult), .RespFlags(RespFlags), .RespErr(RespErr)
  );

  always #5 Clock = ~Clock;

  // ALU model: combinational sum, flags {Z,C,N,O} latched when WF=1
  logic [3:0] alu_flags = 4'b0000;
  logic [W:0] sum;
  logic [3:0] nf;
  always_comb begin
    sum = {1'b0, AluA} + {1'b0, AluB}
        + {{W{1'b0}}, (AluFunSel == ADC) & alu_flags[2]};
    nf  = {sum[W-1:0] == '0, sum[W], sum[W-1],
           (AluA[W-1] == AluB[W-1]) && (sum[W-1] != AluA[W-1])};
  end
  assign AluOut   = sum[W-1:0];
  assign AluFlags = alu_flags;
  always @(posedge Clock) if (AluWF) alu_flags <= nf;

  typedef struct {
    logic [1:0]     op;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic [2*W-1:0] res;
    logic [3:0]     fl;
    logic           err;
    int             lat;
    int             wf;
  } vec_t;

  vec_t vecs[9];
  vec_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int hold);
    int n, lat, wf;
    logic [4:0] fs0, fs1, efs0, efs1;
    vec_t e;
    n = 0;
    while (!ReqReady && n < 20) begin
      @(posedge Clock); #1; n++;
    end
    chk("req_ready", ReqReady, 1);
    RespReady = (hold == 0);
    ReqValid = 1'b1; ReqOp = v.op; ReqA = v.a; ReqB = v.b;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    q.push_back(v);
    lat = 0; wf = 0; fs0 = '0; fs1 = '0;
    while (!RespValid && lat < 10) begin
      if (AluWF) begin
        if (wf == 0) fs0 = AluFunSel; else fs1 = AluFunSel;
        wf++;
      end
      @(posedge Clock); #1; lat++;
    end
    chk("resp_valid", RespValid, 1);
    if (!RespValid) begin
      q.delete();
      RespReady = 1'b1;
      return;
    end
    e = q.pop_front();
    case (e.op)
      2'b00:   begin efs0 = ADD; efs1 = '0;  end
      2'b01:   begin efs0 = ADD; efs1 = ADC; end
      2'b10:   begin efs0 = ADC; efs1 = ADC; end
      default: begin efs0 = '0;  efs1 = '0;  end
    endcase
    chk("result", RespResult, e.res);
    chk("flags", RespFlags, e.fl);
    chk("err", RespErr, e.err);
    chk("latency", lat, e.lat);
    chk("wf_cycles", wf, e.wf);
    chk("funsel_lo", fs0, efs0);
    chk("funsel_hi", fs1, efs1);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clock); #1;
      chk("hold_valid", RespValid, 1);
      chk("hold_result", RespResult, e.res);
      chk("hold_ready", ReqReady, 0);
      chk("hold_wf", AluWF, 0);
    end
    RespReady = 1'b1;
    @(posedge Clock); #1;
    chk("resp_done", RespValid, 0);
  endtask

  initial begin
    int seen;
    vecs[0] = '{2'b01, 64'h00000000_FFFFFFFF, 64'h1,
                64'h00000001_00000000, 4'b0000, 1'b0, 3, 2};
    vecs[1] = '{2'b01, 64'hFFFFFFFF_FFFFFFFF, 64'h1,
                64'h0, 4'b1100, 1'b0, 3, 2};
    vecs[2] = '{2'b10, 64'h0, 64'h0,
                64'h1, 4'b0000, 1'b0, 3, 2};
    vecs[3] = '{2'b00, 64'hDEAD0000_12341234, 64'hBEEF0000_43214321,
                64'h00000000_55555555, 4'b0000, 1'b0, 2, 1};
    vecs[4] = '{2'b00, 64'h7FFFFFFF, 64'h1,
                64'h80000000, 4'b0011, 1'b0, 2, 1};
    vecs[5] = '{2'b01, 64'h00000001_00000000, 64'hFFFFFFFF_00000000,
                64'h0, 4'b1100, 1'b0, 3, 2};
    vecs[6] = '{2'b01, 64'h7FFFFFFF_00000000, 64'h00000001_00000000,
                64'h80000000_00000000, 4'b0011, 1'b0, 3, 2};
    vecs[7] = '{2'b11, 64'h12345678_9ABCDEF0, 64'h1,
                64'h0, 4'b0000, 1'b1, 1, 0};
    vecs[8] = '{2'b01, 64'h00000002_80000000, 64'h00000003_80000000,
                64'h00000006_00000000, 4'b0000, 1'b0, 3, 2};

    #12;
    chk("rst_ready", ReqReady, 0);
    chk("rst_valid", RespValid, 0);
    chk("rst_result", RespResult, 0);
    chk("rst_flags", RespFlags, 0);
    chk("rst_alu", {AluA, AluB, AluFunSel, AluWF, RespErr}, 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("rst_release_ready", ReqReady, 1);

    for (int i = 0; i < 9; i++) run(vecs[i], (i == 3) ? 3 : 0);

    // Reset during the HI pass abandons the operation
    ReqValid = 1'b1; ReqOp = 2'b01;
    ReqA = 64'h11111111_22222222; ReqB = 64'h33333333_44444444;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    @(posedge Clock); #1;
    chk("in_hi_wf", AluWF, 1);
    chk("in_hi_a", AluA, 32'h11111111);
    Reset = 1'b0;
    #1;
    chk("mid_rst_alu", {AluA, AluB, AluFunSel, AluWF}, 0);
    chk("mid_rst_resp", {RespValid, RespResult, RespFlags, RespErr}, 0);
    chk("mid_rst_ready", ReqReady, 0);
    @(negedge Clock);
    Reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      if (RespValid) seen++;
    end
    chk("no_resp_after_rst", seen, 0);
    chk("ready_after_rst", ReqReady, 1);

    run(vecs[3], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
